// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the pc_sequencer instruction-sequencing controller.
// Holds the FSM state encoding, the default address width and the wait-counter sizing.
package pc_sequencer_pkg;

    localparam int DEFAULT_ADDR_W = 2;
    localparam int WAIT_W         = 4;
    localparam logic [7:0] RETIRE_MAX = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == RETIRE_MAX) ? val : val + 8'd1;
    endfunction

    function automatic logic is_busy_state(input seq_state_e st);
        return (st == S_FETCH) || (st == S_DECODE) || (st == S_EXEC);
    endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Combinational next-address select: sequential increment or branch target in EXEC,
// otherwise the current PC. Drives nextaddress toward the external pchandler.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              in_exec,
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] nextaddress
);

    logic [ADDR_W-1:0] pc_inc;

    // Truncation to ADDR_W gives the silent wrap-around at the top of the address space.
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        nextaddress = pc;
        if (in_exec) begin
            nextaddress = branch_taken ? branch_target : pc_inc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer owning the program counter, with imem req/ack handshake.
// Optional macro RETIRE_CNT_EN adds a saturating 8-bit retired-instruction counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_FETCH  | imem_req high, waiting for imem_ack (bounded by MAX_WAIT)
// S_DECODE | one-cycle decode slot
// S_EXEC   | commit nextaddress to pc, or halt on halt_instr
// S_HALTED | stopped by HALT or fetch timeout, waiting for start
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned RESET_PC = 0,
    parameter int          MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              imem_ack,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_instr,
    input  logic              stall,
    output logic              imem_req,
    output logic              ir_load,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] nextaddress,
    output logic              busy,
    output logic              fetch_err,
    output logic [7:0]        retired
);

    localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fetch_err_q, fetch_err_d;
    logic              imem_req_q, imem_req_d;
    logic              busy_q, busy_d;
    logic              ir_load_d;
    logic [ADDR_W-1:0] next_pc;

    pc_next_mux #(
        .ADDR_W(ADDR_W)
    ) u_next_mux (
        .in_exec       (state_q == S_EXEC),
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .nextaddress   (next_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wait_d      = wait_q;
        fetch_err_d = fetch_err_q;
        ir_load_d   = 1'b0;

        if (!stall) begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        pc_d        = PC_INIT;
                        wait_d      = '0;
                        fetch_err_d = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_load_d = !rst;
                        state_d   = S_DECODE;
                        wait_d    = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_HALTED;
                        wait_d      = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    // halt_instr wins over branch_taken: pc is left untouched.
                    if (halt_instr) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        imem_req_d = (state_d == S_FETCH);
        busy_d     = is_busy_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_INIT;
            wait_q      <= '0;
            fetch_err_q <= 1'b0;
            imem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wait_q      <= wait_d;
            fetch_err_q <= fetch_err_d;
            imem_req_q  <= imem_req_d;
            busy_q      <= busy_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [7:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (!stall) begin
            if (start && (state_q == S_IDLE || state_q == S_HALTED)) begin
                retired_d = '0;
            end else if (state_q == S_EXEC && !halt_instr) begin
                retired_d = sat_inc8(retired_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

    assign imem_req    = imem_req_q;
    assign ir_load     = ir_load_d;
    assign pc          = pc_q;
    assign nextaddress = next_pc;
    assign busy        = busy_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized cycles,
// every output compared each cycle against a cycle-level behavioural model.
module tb_pc_sequencer;

    localparam int AW  = 2;
    localparam int RPC = 0;
    localparam int MW  = 3;
    localparam int PC_MOD = 1 << AW;

`ifdef RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_FETCH = 1, M_DECODE = 2, M_EXEC = 3, M_HALTED = 4;

    logic          clk = 1'b0;
    logic          rst, start, imem_ack, branch_taken, halt_instr, stall;
    logic [AW-1:0] branch_target;
    logic          imem_req, ir_load, busy, fetch_err;
    logic [AW-1:0] pc, nextaddress;
    logic [7:0]    retired;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    int m_state, m_pc, m_wait, m_err, m_ret;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W  (AW),
        .RESET_PC(RPC),
        .MAX_WAIT(MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .imem_ack     (imem_ack),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_instr   (halt_instr),
        .stall        (stall),
        .imem_req     (imem_req),
        .ir_load      (ir_load),
        .pc           (pc),
        .nextaddress  (nextaddress),
        .busy         (busy),
        .fetch_err    (fetch_err),
        .retired      (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = RPC;
        m_wait  = 0;
        m_err   = 0;
        m_ret   = 0;
    endtask

    // One clock: drive inputs, check every output against the model, advance the model.
    task automatic cyc(input bit r, input bit s, input bit a, input bit b, input int t,
                       input bit h, input bit st);
        int exp_next;
        rst = r; start = s; imem_ack = a; branch_taken = b;
        branch_target = AW'(t); halt_instr = h; stall = st;
        #1;
        exp_next = (m_state == M_EXEC) ? (b ? (t % PC_MOD) : ((m_pc + 1) % PC_MOD)) : m_pc;
        chk("pc",          32'(pc),          32'(m_pc));
        chk("nextaddress", 32'(nextaddress), 32'(exp_next));
        chk("imem_req",    32'(imem_req),    32'(m_state == M_FETCH));
        chk("busy",        32'(busy),        32'(m_state == M_FETCH || m_state == M_DECODE || m_state == M_EXEC));
        chk("ir_load",     32'(ir_load),     32'(m_state == M_FETCH && a && !st && !r));
        chk("fetch_err",   32'(fetch_err),   32'(m_err));
        chk("retired",     32'(retired),     32'(m_ret));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (!st) begin
            case (m_state)
                M_IDLE, M_HALTED: if (s) begin
                    m_state = M_FETCH; m_pc = RPC; m_wait = 0; m_err = 0; m_ret = 0;
                end
                M_FETCH: begin
                    if (a) begin
                        m_state = M_DECODE; m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == MW) begin
                            m_err = 1; m_state = M_HALTED; m_wait = 0;
                        end
                    end
                end
                M_DECODE: m_state = M_EXEC;
                default: begin
                    if (h) begin
                        m_state = M_HALTED;
                    end else begin
                        m_pc = exp_next;
                        if (CNT_EN && m_ret < 255) m_ret++;
                        m_state = M_FETCH;
                    end
                end
            endcase
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic instr(input bit b, input int t, input bit h);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, b, t, h, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
        branch_target = '0; halt_instr = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Sequential run with wrap 3 -> 0.
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) instr(0, 0, 0);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("retired_4", 32'(retired), CNT_EN ? 32'd4 : 32'd0);

        // Branch at pc=0 to 2, then to 1.
        instr(1, 2, 0);
        chk("branch_pc", 32'(pc), 32'd2);
        instr(1, 1, 0);
        chk("branch_pc1", 32'(pc), 32'd1);

        // Halt beats branch.
        instr(1, 3, 1);
        chk("halt_pc", 32'(pc), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("restart_pc", 32'(pc), 32'(RPC));
        chk("restart_req", 32'(imem_req), 32'd1);

        // Ack timeout.
        for (int i = 0; i < MW; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("timeout_err", 32'(fetch_err), 32'd1);
        chk("timeout_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("err_cleared", 32'(fetch_err), 32'd0);

        // Stall during fetch with ack present.
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("stall_req", 32'(imem_req), 32'd1);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Reset in DECODE.
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'(RPC));
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Randomized cycles.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                $urandom_range(2) == 0, int'($urandom_range(PC_MOD - 1)),
                $urandom_range(7) == 0, $urandom_range(5) == 0);
        end

        // Long run to reach retired-counter saturation.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) instr($urandom_range(1) == 1, int'($urandom_range(PC_MOD - 1)), 0);
        chk("retired_sat", 32'(retired), CNT_EN ? 32'd255 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
